rr_mux41_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for a shared 4:1 multiplexer datapath.
- Four requesters compete for one output channel. The block grants one requester at a time and drives the mux select from a registered value.
- The granted requester's data is forwarded on a valid/ready output channel.
- Sits between requester blocks and any single downstream consumer. Burst length per grant is bounded for fairness.

---
 rtl/rr_mux41_arbiter.sv | 120 ++++++++++++
 tb/tb_rr_mux41_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux41_arbiter.sv
// Round-robin arbiter for four requesters sharing one 4:1 mux datapath.
// Each grant drives a valid/ready output channel and lasts at most MAX_BEATS transfers.
module rr_mux41_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [WIDTH-1:0] data3,
    input  logic             out_ready,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int CW = $clog2(MAX_BEATS + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic [1:0]    r_sel;
    logic [1:0]    w_nextSel;
    logic [1:0]    r_last;
    logic [1:0]    w_nextLast;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_nextCount;
    logic          w_found;
    logic [1:0]    w_winner;
    logic [1:0]    w_idx;
    logic          w_xfer;
    logic          w_lastBeat;

    // Priority scan starts just after the last granted requester and ends on it.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_last;
        w_idx    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_last + 2'(k);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= 2'd0;
            r_last  <= 2'd3;
            r_count <= '0;
        end else begin
            r_state <= w_nextState;
            r_sel   <= w_nextSel;
            r_last  <= w_nextLast;
            r_count <= w_nextCount;
        end
    end

    always_comb begin
        busy      = (r_state == BUSY);
        sel       = r_sel;
        gnt       = 4'b0000;
        out_valid = 1'b0;
        if (busy) begin
            gnt       = 4'b0001 << r_sel;
            out_valid = req[r_sel];
        end
    end

    // The mux follows the registered select in every state, so IDLE shows the last grant's data.
    always_comb begin
        out_data = data0;
        case (r_sel)
            2'd0: out_data = data0;
            2'd1: out_data = data1;
            2'd2: out_data = data2;
            2'd3: out_data = data3;
            default: out_data = data0;
        endcase
    end

    assign w_xfer     = out_valid & out_ready;
    assign w_lastBeat = w_xfer && (r_count == CW'(MAX_BEATS - 1));

    always_comb begin
        w_nextState = r_state;
        w_nextSel   = r_sel;
        w_nextLast  = r_last;
        w_nextCount = r_count;
        if (r_state == IDLE) begin
            if (w_found) begin
                w_nextState = BUSY;
                w_nextSel   = w_winner;
                w_nextCount = '0;
            end
        end else begin
            // A withdrawal on the final beat still counts that beat; either way the grant ends.
            if (!req[r_sel] || w_lastBeat) begin
                w_nextState = IDLE;
                w_nextLast  = r_sel;
                w_nextCount = '0;
            end else if (w_xfer) begin
                w_nextCount = r_count + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_rr_mux41_arbiter.sv
// Randomized bench for rr_mux41_arbiter against a behavioural round-robin model,
// plus directed scenarios with hand-computed expectations.
module tb_rr_mux41_arbiter;

    localparam int WIDTH     = 8;
    localparam int MAX_BEATS = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [3:0]       req = 4'b0000;
    logic [WIDTH-1:0] dataArr [4];
    logic             out_ready = 1'b0;
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    int nChecks = 0;
    int nPass   = 0;

    int mBusy  = 0;
    int mSel   = 0;
    int mLast  = 3;
    int mCount = 0;

    rr_mux41_arbiter #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data0     (dataArr[0]),
        .data1     (dataArr[1]),
        .data2     (dataArr[2]),
        .data3     (dataArr[3]),
        .out_ready (out_ready),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks = nChecks + 1;
        if (act === exp) nPass = nPass + 1;
        else $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
    endtask

    // First requesting index scanning last+1 .. last+4 (mod 4); -1 when nobody requests.
    function automatic int pickWinner(input int last, input logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    // Reference model: who holds the grant, how many beats it has moved, who was served last.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mBusy  <= 0;
            mSel   <= 0;
            mLast  <= 3;
            mCount <= 0;
        end else if (mBusy == 0) begin
            if (pickWinner(mLast, req) >= 0) begin
                mBusy  <= 1;
                mSel   <= pickWinner(mLast, req);
                mCount <= 0;
            end
        end else begin
            if (!req[mSel] || (out_ready && mCount + 1 == MAX_BEATS)) begin
                mBusy  <= 0;
                mLast  <= mSel;
                mCount <= 0;
            end else if (out_ready) begin
                mCount <= mCount + 1;
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("gnt",       32'(gnt),       (mBusy != 0) ? (32'd1 << mSel) : 32'd0);
        checkOutput("sel",       32'(sel),       32'(mSel));
        checkOutput("busy",      32'(busy),      32'(mBusy != 0));
        checkOutput("out_valid", 32'(out_valid), 32'((mBusy != 0) && req[mSel]));
        checkOutput("out_data",  32'(out_data),  32'(dataArr[mSel]));
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic rdy);
        req       = r;
        out_ready = rdy;
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) dataArr[i] = 8'h00;
        #3 rst = 1'b1;
        tick(1);
        checkOutput("reset_gnt",  32'(gnt),       32'd0);
        checkOutput("reset_sel",  32'(sel),       32'd0);
        checkOutput("reset_busy", 32'(busy),      32'd0);
        checkOutput("reset_oval", 32'(out_valid), 32'd0);

        // Single requester: 4 beats, one idle bubble, re-grant.
        rst = 1'b0;
        dataArr[0] = 8'hA5;
        applyStimulus(4'b0001, 1'b1);
        tick(1);
        checkOutput("s1_gnt",   32'(gnt),       32'h1);
        checkOutput("s1_oval",  32'(out_valid), 32'd1);
        checkOutput("s1_odata", 32'(out_data),  32'hA5);
        tick(4);
        checkOutput("s1_bubble", 32'(gnt), 32'h0);
        tick(1);
        checkOutput("s1_regrant", 32'(gnt), 32'h1);

        // All requesting: rotation 0,1,2,3,0.
        pulseReset();
        applyStimulus(4'b1111, 1'b1);
        tick(1);
        checkOutput("s2_g0", 32'(gnt), 32'h1);
        tick(4);
        checkOutput("s2_idle", 32'(gnt), 32'h0);
        tick(1);
        checkOutput("s2_g1", 32'(gnt), 32'h2);
        tick(5);
        checkOutput("s2_g2", 32'(gnt), 32'h4);
        tick(5);
        checkOutput("s2_g3", 32'(gnt), 32'h8);
        tick(5);
        checkOutput("s2_g0b", 32'(gnt), 32'h1);

        // Stalled consumer holds the grant without counting.
        pulseReset();
        dataArr[0] = 8'h11; dataArr[1] = 8'h22; dataArr[2] = 8'h5A; dataArr[3] = 8'h33;
        applyStimulus(4'b0100, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            checkOutput("s3_hold_gnt",  32'(gnt),      32'h4);
            checkOutput("s3_hold_data", 32'(out_data), 32'h5A);
        end
        out_ready = 1'b1;
        tick(3);
        checkOutput("s3_beat3", 32'(gnt), 32'h4);
        tick(1);
        checkOutput("s3_release", 32'(gnt), 32'h0);

        // Requester 1 withdraws after two beats; requester 3 is next in line.
        pulseReset();
        applyStimulus(4'b0010, 1'b1);
        tick(1);
        checkOutput("s4_gnt1", 32'(gnt), 32'h2);
        tick(2);
        applyStimulus(4'b1001, 1'b1);
        tick(1);
        checkOutput("s4_release", 32'(gnt), 32'h0);
        tick(1);
        checkOutput("s4_gnt3", 32'(gnt), 32'h8);

        // Asynchronous reset in the middle of a burst.
        pulseReset();
        applyStimulus(4'b1000, 1'b1);
        tick(3);
        out_ready = 1'b0;
        checkOutput("s5_pre_gnt", 32'(gnt), 32'h8);
        rst = 1'b1;
        #1;
        checkOutput("s5_async_gnt",  32'(gnt),       32'h0);
        checkOutput("s5_async_sel",  32'(sel),       32'h0);
        checkOutput("s5_async_oval", 32'(out_valid), 32'h0);
        #1;
        rst = 1'b0;
        applyStimulus(4'b1111, 1'b1);
        tick(1);
        checkOutput("s5_first", 32'(gnt), 32'h1);

        // Every mux leg, both polarities.
        for (int i = 0; i < 4; i++) begin
            pulseReset();
            for (int j = 0; j < 4; j++) dataArr[j] = (j == i) ? 8'hFF : 8'h00;
            applyStimulus(4'(1 << i), 1'b0);
            tick(1);
            checkOutput("s6_gnt",  32'(gnt),      32'(1 << i));
            checkOutput("s6_ones", 32'(out_data), 32'hFF);
            for (int j = 0; j < 4; j++) dataArr[j] = (j == i) ? 8'h00 : 8'hFF;
            #1;
            checkOutput("s6_zeros", 32'(out_data), 32'h00);
        end

        // Randomized traffic with occasional resets; the model process checks every cycle.
        pulseReset();
        for (int c = 0; c < 3000; c++) begin
            tick(1);
            for (int b = 0; b < 4; b++) req[b] = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int j = 0; j < 4; j++) dataArr[j] = 8'($urandom);
            if ($urandom_range(0, 199) == 0) pulseReset();
        end
        tick(2);

        $display("[TB] %0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
